// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_t          FSM state encoding. Both ends use the same codes,
//                         so debug LEDs read the same way on either side.
//   DEFAULT_CLKS_PER_BIT  bit period in clocks (100 MHz / 115200 baud).
//   DEFAULT_STOP_BITS     number of stop bits per frame.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'b000,
      START   = 3'b001,
      DATA    = 3'b010,
      STOP    = 3'b011,
      CLEANUP = 3'b111
   } uart_state_t;

   localparam int DEFAULT_CLKS_PER_BIT = 868;
   localparam int DEFAULT_STOP_BITS    = 1;

endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter (LSB first, STOP_BITS stop bits).
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-low reset
//   i_valid     host offers the byte on i_byte
//   i_byte      byte to send, captured only on an accept edge
//   o_ready     high in IDLE; accept = i_valid & o_ready at a rising edge
//   serial_out  registered TX line, idles high
//   o_busy      high in every state except IDLE
//   o_done      one-cycle pulse in CLEANUP, after the last stop bit
//   state       current FSM state (debug / LEDs)
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = DEFAULT_STOP_BITS
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       i_valid,
   input  logic [7:0] i_byte,
   output logic       o_ready,
   output logic       serial_out,
   output logic       o_busy,
   output logic       o_done,
   output logic [2:0] state
);

   // The counter must reach the longest interval, which is the whole stop
   // period when two stop bits are used.
   localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);

   uart_state_t      state_reg,   state_next;
   logic [CNT_W-1:0] clock_count, count_next;
   logic [2:0]       bit_index,   index_next;
   logic [7:0]       shift,       shift_next;
   logic             line,        line_next;
   logic [2:0]       index_inc;

   assign index_inc = bit_index + 3'd1;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg   <= IDLE;
         clock_count <= '0;
         bit_index   <= '0;
         shift       <= '0;
         line        <= 1'b1;
      end else begin
         state_reg   <= state_next;
         clock_count <= count_next;
         bit_index   <= index_next;
         shift       <= shift_next;
         line        <= line_next;
      end
   end

   // The line level is computed for the state being entered, so serial_out
   // is a plain register and only moves on bit boundaries.
   always_comb begin
      state_next = state_reg;
      count_next = clock_count;
      index_next = bit_index;
      shift_next = shift;
      line_next  = line;
      case (state_reg)
         IDLE: begin
            line_next = 1'b1;
            if (i_valid) begin
               shift_next = i_byte;
               count_next = '0;
               line_next  = 1'b0;
               state_next = START;
            end
         end
         START: begin
            if (clock_count == BIT_LAST) begin
               count_next = '0;
               index_next = '0;
               line_next  = shift[0];
               state_next = DATA;
            end else begin
               count_next = clock_count + CNT_W'(1);
            end
         end
         DATA: begin
            if (clock_count == BIT_LAST) begin
               count_next = '0;
               if (bit_index == 3'd7) begin
                  index_next = '0;
                  line_next  = 1'b1;
                  state_next = STOP;
               end else begin
                  index_next = index_inc;
                  line_next  = shift[index_inc];
               end
            end else begin
               count_next = clock_count + CNT_W'(1);
            end
         end
         STOP: begin
            if (clock_count == STOP_LAST) begin
               count_next = '0;
               line_next  = 1'b1;
               state_next = CLEANUP;
            end else begin
               count_next = clock_count + CNT_W'(1);
            end
         end
         CLEANUP: begin
            line_next  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            // Unreachable codes recover to an idle line.
            count_next = '0;
            index_next = '0;
            line_next  = 1'b1;
            state_next = IDLE;
         end
      endcase
   end

   assign serial_out = line;
   assign o_ready    = (state_reg == IDLE);
   assign o_busy     = (state_reg != IDLE);
   assign o_done     = (state_reg == CLEANUP);
   assign state      = state_reg;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: bench for uart_tx. Three instances share clock and reset:
//   u0: CLKS_PER_BIT=4, STOP_BITS=1
//   u1: CLKS_PER_BIT=4, STOP_BITS=2
//   u2: CLKS_PER_BIT=868, STOP_BITS=1 (full-rate, decoded like the receiver)
// Stimulus pushes expected bytes into a per-instance queue; a monitor per
// instance decodes each frame from serial_out and checks it against the queue.
module tb_uart_tx;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] valid_v = 3'b000;
   logic [7:0] byte_a [3];
   logic [2:0] line_v, done_v, busy_v, ready_v;
   logic [2:0] state0, state1, state2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] q0[$], q1[$], q2[$];
   int         st0[$], st1[$], st2[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u0 (
      .clock(clock), .reset(reset), .i_valid(valid_v[0]), .i_byte(byte_a[0]),
      .o_ready(ready_v[0]), .serial_out(line_v[0]), .o_busy(busy_v[0]),
      .o_done(done_v[0]), .state(state0));

   uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u1 (
      .clock(clock), .reset(reset), .i_valid(valid_v[1]), .i_byte(byte_a[1]),
      .o_ready(ready_v[1]), .serial_out(line_v[1]), .o_busy(busy_v[1]),
      .o_done(done_v[1]), .state(state1));

   uart_tx #(.CLKS_PER_BIT(868), .STOP_BITS(1)) u2 (
      .clock(clock), .reset(reset), .i_valid(valid_v[2]), .i_byte(byte_a[2]),
      .o_ready(ready_v[2]), .serial_out(line_v[2]), .o_busy(busy_v[2]),
      .o_done(done_v[2]), .state(state2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_exp(input int w, input logic [7:0] b);
      if (w == 0) q0.push_back(b);
      else if (w == 1) q1.push_back(b);
      else q2.push_back(b);
   endtask

   function automatic int qsize(input int w);
      if (w == 0) return q0.size();
      else if (w == 1) return q1.size();
      else return q2.size();
   endfunction

   task automatic pop_exp(input int w, output logic ok, output logic [7:0] b);
      ok = (qsize(w) != 0);
      b  = 8'h00;
      if (ok) begin
         if (w == 0) b = q0.pop_front();
         else if (w == 1) b = q1.pop_front();
         else b = q2.pop_front();
      end
   endtask

   task automatic push_start(input int w, input int t);
      if (w == 0) st0.push_back(t);
      else if (w == 1) st1.push_back(t);
      else st2.push_back(t);
   endtask

   // Frame decoder: every sample of every bit period is checked, so both the
   // bit value and the exact period length are verified.
   task automatic monitor(input int w, input int cpb, input int stops);
      logic prev, first, v, stable, levels, abort, early, ok;
      logic [7:0] data, e;
      prev = 1'b1;
      forever begin
         @(negedge clock);
         if (reset === 1'b1 && prev === 1'b1 && line_v[w] === 1'b0) begin
            push_start(w, cyc);
            stable = 1'b1; levels = 1'b1; abort = 1'b0; early = 1'b0;
            data = 8'h00; first = 1'b0;
            for (int k = 0; k < 9 + stops && !abort; k++) begin
               for (int c = 0; c < cpb && !abort; c++) begin
                  if (k != 0 || c != 0) @(negedge clock);
                  if (reset !== 1'b1) abort = 1'b1;
                  else begin
                     v = line_v[w];
                     if (done_v[w] !== 1'b0) early = 1'b1;
                     if (c == 0) first = v;
                     else if (v !== first) stable = 1'b0;
                  end
               end
               if (!abort) begin
                  if (k == 0) begin
                     if (first !== 1'b0) levels = 1'b0;
                  end else if (k <= 8) begin
                     data[k-1] = first;
                  end else if (first !== 1'b1) begin
                     levels = 1'b0;
                  end
               end
            end
            if (!abort) begin
               @(negedge clock);
               chk("done_early", {31'd0, early}, 32'd0);
               chk("done_pulse", {31'd0, done_v[w]}, 32'd1);
               chk("cleanup_line", {31'd0, line_v[w]}, 32'd1);
               chk("bit_stable", {31'd0, stable}, 32'd1);
               chk("frame_levels", {31'd0, levels}, 32'd1);
               pop_exp(w, ok, e);
               if (ok) chk("data_byte", {24'd0, data}, {24'd0, e});
               else chk("unexpected_frame", {24'd0, data}, 32'hFFFF_FFFF);
               @(negedge clock);
               chk("done_width", {31'd0, done_v[w]}, 32'd0);
            end
            prev = line_v[w];
         end else begin
            prev = line_v[w];
         end
      end
   endtask

   initial monitor(0, 4, 1);
   initial monitor(1, 4, 2);
   initial monitor(2, 868, 1);

   // Offer one byte and hold i_valid until the instance goes busy.
   task automatic send(input int w, input logic [7:0] b);
      int n;
      @(negedge clock);
      valid_v[w] = 1'b1;
      byte_a[w]  = b;
      push_exp(w, b);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (busy_v[w] !== 1'b1 && n < 50);
      if (busy_v[w] !== 1'b1) chk("accept_timeout", {31'd0, busy_v[w]}, 32'd1);
      valid_v[w] = 1'b0;
   endtask

   task automatic wait_idle(input int w, input int budget);
      int n;
      n = 0;
      while ((qsize(w) != 0 || busy_v[w] !== 1'b0) && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (n >= budget) chk("idle_timeout", qsize(w), 32'd0);
   endtask

   task automatic wait_busy(input int w, input logic lvl);
      int n;
      n = 0;
      while (busy_v[w] !== lvl && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (busy_v[w] !== lvl) chk("busy_timeout", {31'd0, busy_v[w]}, {31'd0, lvl});
   endtask

   // i_valid held across two frames: minimum spacing, and i_byte changes
   // while busy must not leak into the frame in flight.
   task automatic back_to_back(input int w, input logic [7:0] b1, input logic [7:0] b2,
                               input int gap);
      int n0;
      n0 = (w == 0) ? st0.size() : st1.size();
      @(negedge clock);
      valid_v[w] = 1'b1;
      byte_a[w]  = b1;
      push_exp(w, b1);
      push_exp(w, b2);
      wait_busy(w, 1'b1);
      repeat (10) @(negedge clock);
      byte_a[w] = 8'h55;
      repeat (20) @(negedge clock);
      byte_a[w] = b2;
      wait_busy(w, 1'b0);
      wait_busy(w, 1'b1);
      valid_v[w] = 1'b0;
      wait_idle(w, 200);
      if (w == 0) begin
         chk("b2b_frames", st0.size() - n0, 32'd2);
         if (st0.size() == n0 + 2) chk("b2b_gap", st0[n0+1] - st0[n0], gap);
      end else begin
         chk("b2b_frames", st1.size() - n0, 32'd2);
         if (st1.size() == n0 + 2) chk("b2b_gap", st1[n0+1] - st1[n0], gap);
      end
   endtask

   initial begin
      int seen;
      int n0;
      byte_a[0] = 8'h00; byte_a[1] = 8'h00; byte_a[2] = 8'h00;

      // Reset held for three cycles.
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("rst_line", {31'd0, line_v[0]}, 32'd1);
      chk("rst_ready", {31'd0, ready_v[0]}, 32'd1);
      chk("rst_state", {29'd0, state0}, 32'd0);
      chk("rst_done", {31'd0, done_v[0]}, 32'd0);
      chk("rst_busy", {31'd0, busy_v[0]}, 32'd0);
      chk("rst_line_u1", {31'd0, line_v[1]}, 32'd1);
      chk("rst_line_u2", {31'd0, line_v[2]}, 32'd1);

      // Single frame 0xA5: line 0,1,0,1,0,0,1,0,1,1; done 40 cycles after start.
      send(0, 8'hA5);
      wait_idle(0, 200);

      // Reset during data bit 3 aborts the frame.
      send(0, 8'hC3);
      repeat (16) @(negedge clock);
      chk("mid_state_data", {29'd0, state0}, 32'd2);
      reset = 1'b0;
      @(negedge clock);
      chk("abort_line", {31'd0, line_v[0]}, 32'd1);
      chk("abort_state", {29'd0, state0}, 32'd0);
      chk("abort_done", {31'd0, done_v[0]}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      q0.delete();
      seen = 0;
      repeat (60) begin
         @(negedge clock);
         if (done_v[0] !== 1'b0) seen++;
      end
      chk("abort_no_done", seen, 32'd0);

      // Back-to-back frames with i_valid held high.
      back_to_back(0, 8'h00, 8'hFF, 42);

      // Two stop bits: 0xFF twice, start-to-start spacing 46.
      back_to_back(1, 8'hFF, 8'hFF, 46);

      // i_valid pulse during STOP is ignored.
      n0 = st0.size();
      send(0, 8'h5A);
      repeat (37) @(negedge clock);
      chk("in_stop", {29'd0, state0}, 32'd3);
      valid_v[0] = 1'b1;
      byte_a[0]  = 8'h12;
      @(negedge clock);
      valid_v[0] = 1'b0;
      wait_idle(0, 200);
      repeat (60) @(negedge clock);
      chk("busy_reject", st0.size() - n0, 32'd1);

      // Full-rate frames decoded the way the receiver samples them.
      send(2, 8'h3C); wait_idle(2, 12000);
      send(2, 8'h00); wait_idle(2, 12000);
      send(2, 8'hFF); wait_idle(2, 12000);
      send(2, 8'h81); wait_idle(2, 12000);
      chk("full_rate_frames", st2.size(), 32'd4);

      repeat (5) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter; the transmit counterpart of the team's existing UART receiver on the same serial link.
- Accepts one byte per valid/ready handshake from the host-side logic and serialises it LSB first: start bit, 8 data bits, STOP_BITS stop bits.
- Bit period is a fixed clock count, identical to the receiver's, so the two ends interoperate directly and in loopback.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per bit (100 MHz / 115200 baud); legal values ≥ 2.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- i_valid  input  1  host presents a byte on i_byte.
- i_byte  input  8  byte to transmit; sampled only on an accept edge.
- o_ready  output  1  high only in IDLE; accept = i_valid & o_ready at a rising edge.
- serial_out  output  1  registered TX line; idle level 1.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse in CLEANUP, after the last stop bit.
- state  output  3  current FSM state, for debug and LEDs.

Behaviour:
- Clocking: all state is updated on posedge clock; no combinational path from i_valid to serial_out.
- Reset: reset=0 at an edge gives, at the next edge:
  - state=IDLE, serial_out=1, o_done=0, o_busy=0, o_ready=1 (once reset is released).
  - Shift register, bit index and counter all 0.
  - A reset mid-frame aborts the frame immediately; no partial-frame completion and no o_done.
- State encodings (same as the receiver): IDLE=000, START=001, DATA=010, STOP=011, CLEANUP=111. Other codes go to IDLE on the next edge with serial_out=1.
- IDLE:
  - serial_out=1, o_ready=1.
  - On accept: capture i_byte into the shift register, clear the counter, go to START.
  - Later changes to i_byte are ignored.
- START: serial_out=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - serial_out=byte[bit_index] for exactly CLKS_PER_BIT cycles per bit, LSB first.
  - After bit 7, go to STOP.
  - bit_index is 3 bits and wraps back to 0 on exit.
- STOP: serial_out=1 for exactly STOP_BITS*CLKS_PER_BIT cycles, then go to CLEANUP.
- CLEANUP:
  - Lasts exactly one cycle: o_done=1, serial_out=1, o_ready=0.
  - Then go to IDLE.
- Latency and timing:
  - The first edge after accept drives the start bit.
  - o_done asserts (1+8+STOP_BITS)*CLKS_PER_BIT cycles after the start bit begins.
  - Minimum start-to-start spacing between back-to-back frames is (9+STOP_BITS)*CLKS_PER_BIT + 2 cycles (CLEANUP plus one IDLE accept cycle).
- Handshake:
  - i_valid while busy is ignored; there is no queue and no error flag.
  - The host must hold i_valid until it sees o_ready.
  - i_valid held continuously gives back-to-back frames at the minimum spacing.
- Counter: clock_count is wide enough for STOP_BITS*CLKS_PER_BIT-1 and resets to 0 on every bit boundary. Compare with "== limit-1", never ">".
- Glitch-free: serial_out changes only on bit boundaries.

Decomposition:
- Shared package uart_pkg:
  - State localparams: IDLE, START, DATA, STOP, CLEANUP.
  - Default CLKS_PER_BIT (868).
  - This replaces the duplicated localparams in the receiver.
- Optional sub-module uart_bit_timer (counter plus a one-cycle "bit_end" strobe, parameter LIMIT), reusable later by the receiver. Otherwise the block is a single module.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset behaviour: reset held low 3 cycles, then released → serial_out=1, o_ready=1, state=000, o_done=0. Reset asserted during DATA bit 3 → serial_out=1 and state=000 on the next edge, with no o_done ever.
- Single frame: send 0xA5 → line reads 0,1,0,1,0,0,1,0,1,1, each level held for exactly 4 cycles. o_done pulses exactly 1 cycle, 40 cycles after the start-bit edge.
- STOP_BITS=2: send 0xFF → 0 for 4 cycles, 1 for 40 cycles (data plus stop), then o_done. The next start bit occurs no earlier than 46 cycles after the previous start.
- Back-to-back with i_byte changing mid-frame: i_valid held high with 0x00 then 0xFF → two frames 42 cycles apart, with data exactly 0x00 then 0xFF. A change of i_byte to 0x55 during frame 1 does not corrupt the frame.
- Busy rejection: pulse i_valid with 0x12 during the STOP state → ignored; no extra frame is sent.
- Loopback with the receiver (CLKS_PER_BIT=868): serial_out wired to serial_in, send 0x3C, 0x00, 0xFF, 0x81 → the receiver reports o_Byte equal to each byte, with one o_done per frame.
